// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes columns, debounces whole-keypad frames and
// reports single-key presses through a one-entry valid/ready buffer.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overrun
);

  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STAB_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_CNT);

  typedef enum logic {IDLE, HELD} state_t;

  state_t            state_q, state_d;
  logic [3:0]        sync1_q, sync1_d;
  logic [3:0]        sync2_q, sync2_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [15:0]       snap_q, snap_d;
  logic [15:0]       prev_snap_q, prev_snap_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              overrun_q, overrun_d;

  logic              col_tick;
  logic              frame_end;
  logic              stable_evt;
  logic              one_hot;
  logic              emit;
  logic [3:0]        hot_code;
  logic [3:0]        bit_idx;

  always_comb begin
    state_d     = state_q;
    sync1_d     = row;
    sync2_d     = sync1_q;
    div_cnt_d   = div_cnt_q;
    col_idx_d   = col_idx_q;
    snap_d      = snap_q;
    prev_snap_d = prev_snap_q;
    stab_cnt_d  = stab_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    stable_evt  = 1'b0;
    emit        = 1'b0;
    hot_code    = 4'd0;
    bit_idx     = 4'd0;

    col_tick  = (div_cnt_q == DIV_LAST);
    frame_end = col_tick && (col_idx_q == 2'd3);

    if (col_tick) begin
      div_cnt_d = '0;
      col_idx_d = col_idx_q + 2'd1;
      snap_d[{col_idx_q, 2'b00} +: 4] = ~sync2_q;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end

    // Compare the frame including the column-3 nibble captured this cycle.
    if (frame_end) begin
      prev_snap_d = snap_d;
      if (snap_d == prev_snap_q) begin
        if (stab_cnt_q != STAB_MAX) begin
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
        stable_evt = (stab_cnt_q == STAB_MAX - 1'b1);
      end else begin
        stab_cnt_d = STAB_W'(1);
      end
    end

    one_hot = (snap_d != 16'd0) && ((snap_d & (snap_d - 16'd1)) == 16'd0);
    for (int i = 0; i < 16; i++) begin
      if (snap_d[i]) begin
        bit_idx  = 4'(i);
        hot_code = {bit_idx[1:0], bit_idx[3:2]};
      end
    end

    case (state_q)
      IDLE: begin
        if (stable_evt && one_hot) begin
          emit    = 1'b1;
          state_d = HELD;
        end
      end
      HELD: begin
        if (stable_evt && (snap_d == 16'd0)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A press arriving while the buffer is full is dropped, never overwritten.
    if (emit) begin
      if (!key_valid_q || key_ready) begin
        key_code_d  = hot_code;
        key_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (key_valid_q && key_ready) begin
      key_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync1_q     <= 4'hF;
      sync2_q     <= 4'hF;
      div_cnt_q   <= '0;
      col_idx_q   <= 2'd0;
      snap_q      <= 16'd0;
      prev_snap_q <= 16'd0;
      stab_cnt_q  <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      div_cnt_q   <= div_cnt_d;
      col_idx_q   <= col_idx_d;
      snap_q      <= snap_d;
      prev_snap_q <= prev_snap_d;
      stab_cnt_q  <= stab_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign col       = ~(4'b0001 << col_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = (state_q == HELD);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a frame-level keypad model predicts every output each
// cycle; directed scenarios pin it with literal expectations, then random presses.
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DC = 3;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;
  logic       overrun;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .key_code(key_code),
    .key_valid(key_valid), .key_ready(key_ready), .key_held(key_held), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Model state: pressed keys indexed by key code, pin history, frame snapshots.
  logic [15:0] m_p;
  logic [3:0]  r_m1, r_m2;
  logic [15:0] m_snap, m_prev;
  int          m_stab;
  bit          m_held, m_valid, m_ovr;
  logic [3:0]  m_code;
  int          t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
  endtask

  function automatic int popc(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) if (v[i]) n++;
    return n;
  endfunction

  task automatic model_update();
    if (!rst_n) begin
      t = 0; r_m1 = 4'hF; r_m2 = 4'hF; m_snap = '0; m_prev = '0; m_stab = 0;
      m_held = 0; m_valid = 0; m_code = '0; m_ovr = 0;
    end else begin
      int  pos = t % SD;
      int  c   = (t / SD) % 4;
      int  old;
      bit  loaded = 0;
      bit  accept = m_valid && key_ready;
      if (pos == SD - 1) begin
        for (int r = 0; r < 4; r++) m_snap[c*4 + r] = ~r_m2[r];
        if (c == 3) begin
          old = m_stab;
          if (m_snap == m_prev) m_stab = (m_stab < DC) ? m_stab + 1 : DC;
          else m_stab = 1;
          m_prev = m_snap;
          if (m_stab == DC && old != DC) begin
            if (!m_held) begin
              if (popc(m_snap) == 1) begin
                if (!m_valid || key_ready) begin
                  for (int i = 0; i < 16; i++)
                    if (m_snap[i]) m_code = 4'((i % 4) * 4 + i / 4);
                  m_valid = 1; loaded = 1;
                end else begin
                  m_ovr = 1;
                end
                m_held = 1;
              end
            end else if (m_snap == 16'd0) begin
              m_held = 0;
            end
          end
        end
      end
      if (accept && !loaded) m_valid = 0;
      r_m2 = r_m1;
      r_m1 = row;
      t++;
    end
  endtask

  // Keypad physics: a pressed key pulls its row low while its column is strobed.
  task automatic drive_row();
    int c = (t / SD) % 4;
    logic [3:0] r_v;
    for (int r = 0; r < 4; r++) r_v[r] = ~m_p[r*4 + c];
    row = r_v;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    drive_row();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!key_valid && n < max) begin
      step();
      n++;
    end
    if (!key_valid) check("wait_valid_timeout", key_valid, 1);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("col", col, 4'hF ^ (4'h1 << ((t / SD) % 4)));
      check("key_valid", key_valid, m_valid);
      check("key_code", key_code, m_code);
      check("key_held", key_held, m_held);
      check("overrun", overrun, m_ovr);
    end
  end

  initial begin
    int  n;
    bit  seen;
    logic [3:0] col_tab [4];
    col_tab[0] = 4'b1110; col_tab[1] = 4'b1101; col_tab[2] = 4'b1011; col_tab[3] = 4'b0111;

    rst_n = 1'b0; key_ready = 1'b0; m_p = '0; row = 4'hF; t = 0;
    run(2);
    chk_en = 1'b1;
    check("rst_col", col, 4'b1110);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);
    check("rst_overrun", overrun, 0);
    check("rst_code", key_code, 0);
    rst_n = 1'b1;

    // Scan order with no key pressed.
    seen = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (key_valid) seen = 1;
      if (k % 4 == 3) check("scan_col", col, col_tab[(k / 4) % 4]);
    end
    check("scan_wrap_col", col, 4'b1110);
    check("scan_no_valid", seen, 0);

    // Key 6 (row 1, col 2) pressed from a frame start.
    m_p = 16'h0040;
    run(47);
    check("single_early", key_valid, 0);
    step();
    check("single_valid", key_valid, 1);
    check("single_code", key_code, 6);
    check("single_held", key_held, 1);
    key_ready = 1'b1; step(); key_ready = 1'b0;
    check("single_accept", key_valid, 0);

    // Bounce: toggle key 6 every frame.
    m_p = '0; run(6 * FRAME);
    check("release_idle", key_held, 0);
    seen = 0;
    for (int f = 0; f < 10; f++) begin
      m_p = (f % 2 == 0) ? 16'h0040 : 16'h0000;
      repeat (FRAME) begin
        step();
        if (key_valid || key_held) seen = 1;
      end
    end
    check("bounce_quiet", seen, 0);
    m_p = 16'h0040;
    wait_valid(100, n);
    check("bounce_code", key_code, 6);
    check("bounce_latency_ok", (n >= 35 && n <= 50), 1);
    key_ready = 1'b1; step(); key_ready = 1'b0;

    // Ghosting: keys 0 and 5 together.
    m_p = '0; run(6 * FRAME);
    m_p = 16'h0021;
    seen = 0;
    repeat (6 * FRAME) begin
      step();
      if (key_valid) seen = 1;
    end
    check("ghost_no_valid", seen, 0);
    m_p = '0; run(6 * FRAME);
    m_p = 16'h8000;
    wait_valid(100, n);
    check("key15_code", key_code, 15);
    key_ready = 1'b1; step(); key_ready = 1'b0;

    // Overrun: second press while the first is still pending.
    m_p = '0; run(6 * FRAME);
    m_p = 16'h0040;
    wait_valid(100, n);
    check("ovr_first_code", key_code, 6);
    m_p = '0; run(6 * FRAME);
    m_p = 16'h0200;
    run(5 * FRAME);
    check("ovr_code_kept", key_code, 6);
    check("ovr_flag", overrun, 1);
    check("ovr_valid", key_valid, 1);
    key_ready = 1'b1; step(); key_ready = 1'b0;
    check("ovr_accept_valid", key_valid, 0);
    check("ovr_sticky", overrun, 1);

    // Reset with a pending key, a held key and overrun set.
    m_p = '0; run(6 * FRAME);
    m_p = 16'h0040;
    wait_valid(100, n);
    check("pre_rst_held", key_held, 1);
    check("pre_rst_ovr", overrun, 1);
    rst_n = 1'b0; step();
    check("mid_rst_valid", key_valid, 0);
    check("mid_rst_held", key_held, 0);
    check("mid_rst_ovr", overrun, 0);
    check("mid_rst_col", col, 4'b1110);
    m_p = '0; step();
    rst_n = 1'b1;

    // Random presses, bounces, chords and handshakes.
    for (int seg = 0; seg < 150; seg++) begin
      int r = $urandom_range(0, 99);
      if (r < 3) begin
        rst_n = 1'b0; run(2); rst_n = 1'b1;
        continue;
      end
      if (r < 55)      m_p = 16'h1 << $urandom_range(0, 15);
      else if (r < 75) m_p = '0;
      else if (r < 88) m_p = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      else             m_p = 16'($urandom);
      repeat ($urandom_range(1, 80)) begin
        key_ready = ($urandom_range(0, 3) == 0);
        step();
      end
    end
    key_ready = 1'b0;
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

- Scans a 4x4 matrix keypad and delivers debounced single-key press events to the CPU input path.
- Input-side counterpart of the multiplexed seven-segment display driver:
  - drives one active-low column strobe at a time;
  - samples the active-low row lines;
  - debounces whole-keypad snapshots;
  - presents each new press as a 4-bit key code on a valid/ready handshake with a one-entry buffer.

## Interface
- SCAN_DIV, default 1000: clock cycles each column stays strobed; minimum 4.
- DEBOUNCE_CNT, default 4: consecutive identical frames required before a snapshot counts as stable; minimum 2.
- clk  input  1  system clock; every register updates on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- row  input  4  keypad rows; active-low, externally pulled up, asynchronous to clk.
- col  output  4  column strobes; active-low, exactly one bit low at any time.
- key_code  output  4  code of the pending key: row_idx*4 + col_idx.
- key_valid  output  1  a key code is pending.
- key_ready  input  1  consumer accepts key_code when high together with key_valid.
- key_held  output  1  the debounced state holds a reported key that has not yet been released.
- overrun  output  1  sticky flag: a press was dropped because the buffer was full.

## Operation
- **Synchronizer:** row passes through a 2-flop synchronizer before use.
- **Scan:**
  - A column counter cycles 0..3. Column c is strobed with col[c]=0 and all other bits 1.
  - A divide counter runs 0..SCAN_DIV-1 per column.
  - At divide count SCAN_DIV-1, the inverted synchronized row is written to snapshot bits [c*4 +: 4], then the column advances.
  - The column counter wraps 3 -> 0.
- **Frame:** one pass over columns 0..3 (4*SCAN_DIV cycles). The frame ends at the column-3 sample.
- **Debounce, at each frame end:**
  - If snapshot equals the previous frame's snapshot, stab_cnt increments, saturating at DEBOUNCE_CNT. Otherwise stab_cnt is set to 1.
  - The stable event fires on the frame end where stab_cnt becomes DEBOUNCE_CNT. It fires once per stable period.
- **FSM states: IDLE, HELD.**
  - IDLE, stable event with exactly one bit set: emit the key; go to HELD.
  - IDLE, stable event with zero bits or 2+ bits set (ghosting): no emit; stay in IDLE.
  - HELD, stable event with all-zero snapshot: go to IDLE.
  - HELD, any other stable event: ignored, including a different single key; a new key is reported only after a release.
  - key_held = (state == HELD).
- **Emit:**
  - If key_valid=0, or key_valid=1 and key_ready=1 in the same cycle: load key_code and set key_valid=1.
  - Otherwise: keep the old code and set overrun=1.
- **Handshake:**
  - key_valid falls on the cycle after key_valid && key_ready, unless an emit coincides with it.
  - key_code stays stable while key_valid=1.
- **overrun** clears only on reset.

## Timing
- **Reset values (rst_n=0 at a clock edge):**
  - Outputs: col=4'b1110, key_code=0, key_valid=0, key_held=0, overrun=0.
  - Internal: FSM=IDLE, all counters=0, synchronizer=4'b1111, snapshot=0, previous snapshot=0.
- **Reset mid-operation:** discards a pending key and any debounce progress. Scanning restarts at column 0 on the first cycle with rst_n=1.
- **Column changes:** occur on the clock edge after divide count SCAN_DIV-1.
- **Row settling:** the row sample reflects pins held at least 2 cycles before the sampling edge. SCAN_DIV>=4 guarantees this across the column switch.
- **Press latency:** key_valid rises 1 cycle after the frame end that produces the stable event. A clean press present for a whole frame is therefore reported DEBOUNCE_CNT frame ends after its first fully-sampled frame.
- **Simultaneous accept and emit:** the new code loads, key_valid stays 1, and overrun is not set.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_CNT=3, so one frame is 16 cycles.

- **Reset and scan order:** hold rst_n=0 then release; row=4'b1111.
  - col must be 1110 for 4 cycles, then 1101, 1011, 0111, then 1110 again.
  - key_valid must stay 0 throughout.
- **Single key:** model key (row 1, col 2) from frame start (row[1]=0 whenever col[2]=0); key_ready=0.
  - key_valid=1 with key_code=6 one cycle after the 3rd frame end; key_held=1.
  - Pulse key_ready: key_valid=0 on the next cycle.
- **Bounce:** alternate key 6 pressed and released every frame for 10 frames.
  - key_valid stays 0 and key_held stays 0.
  - Then hold key 6: reported after 3 stable frames.
- **Ghosting and release:** press keys 0 and 5 together for 6 frames.
  - No key_valid. After release, press key 15 alone: key_code=15.
- **Overrun:** key_ready=0. Press key 6, release it for 3+ frames, then press key 9.
  - key_code stays 6 and overrun=1.
  - Accepting with key_ready clears key_valid; overrun stays 1.
- **Reset mid-operation:** assert rst_n=0 while key_valid=1, key_held=1, overrun=1.
  - After the next edge all three are 0 and col=1110.
